// File: rtl/mac_opfetch.sv
// mac_opfetch: AHB-Lite read master that fetches the two memory operands of
// MAC.W / MAC.L (@Rm+,@Rn+). One request carries both addresses; two
// pipelined single reads are issued and each operand is returned on rslt
// with a one-cycle rdy strobe.
// Optional feature macro: MAC_OPF_MISALIGN_EN (reject misaligned requests
// with an err pulse instead of silently aligning the addresses).
module mac_opfetch #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_l,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              flush,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [31:0]       rslt,
    output logic              rdy,
    output logic              bsy,
    output logic              err
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    // A0: op0 address phase; A1D0: op1 address + op0 data; D1: op1 data.
    // ERRW: second cycle of an error response; FLSH: silent drain after flush.
    typedef enum logic [2:0] {
        S_IDLE, S_A0, S_A1D0, S_D1, S_ERRW, S_FLSH
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] a0_q, a1_q;
    logic              lw_q;
    logic              lat;
    logic              rdy_nxt;
    logic              err_nxt;
    logic              cap_hi;

    // Extract the operand from the bus word: full word for L, selected lane for W.
    function automatic logic [31:0] lane_sel(input logic [31:0] d, input logic hi_addr,
                                             input logic l);
        logic [15:0] half;
        if (BIG_ENDIAN)
            half = hi_addr ? d[15:0] : d[31:16];
        else
            half = hi_addr ? d[31:16] : d[15:0];
        return l ? d : {16'h0000, half};
    endfunction

`ifdef MAC_OPF_MISALIGN_EN
    function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic l);
        return l ? (a[1] | a[0]) : a[0];
    endfunction
`else
    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input logic l);
        logic [ADDR_W-1:0] r;
        r    = a;
        r[0] = 1'b0;
        if (l)
            r[1] = 1'b0;
        return r;
    endfunction
`endif

    assign HWRITE = 1'b0;
    assign bsy    = (state != S_IDLE);

    // State register and registered operand/strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rdy   <= 1'b0;
            err   <= 1'b0;
            rslt  <= '0;
        end else begin
            state <= state_nxt;
            rdy   <= rdy_nxt;
            err   <= err_nxt;
            if (rdy_nxt)
                rslt <= lane_sel(HRDATA, cap_hi, lw_q);
        end
    end

    // Request latch; contents only matter while the FSM is busy.
    always_ff @(posedge clk) begin
        if (lat) begin
`ifdef MAC_OPF_MISALIGN_EN
            a0_q <= addr0;
            a1_q <= addr1;
`else
            a0_q <= align(addr0, req_l);
            a1_q <= align(addr1, req_l);
`endif
            lw_q <= req_l;
        end
    end

    // Next-state, bus address/control and capture decisions.
    always_comb begin
        state_nxt = state;
        HTRANS    = TR_IDLE;
        HADDR     = '0;
        HSIZE     = 3'b010;
        lat       = 1'b0;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
        cap_hi    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
`ifdef MAC_OPF_MISALIGN_EN
                    if (misaligned(addr0, req_l) || misaligned(addr1, req_l)) begin
                        err_nxt = 1'b1;
                    end else begin
                        lat       = 1'b1;
                        state_nxt = S_A0;
                    end
`else
                    lat       = 1'b1;
                    state_nxt = S_A0;
`endif
                end
            end
            S_A0: begin
                HTRANS = TR_NONSEQ;
                HADDR  = a0_q;
                HSIZE  = lw_q ? 3'b010 : 3'b001;
                // If op0's address phase was accepted, its data phase must still drain.
                if (flush)
                    state_nxt = HREADY ? S_FLSH : S_IDLE;
                else if (HREADY)
                    state_nxt = S_A1D0;
            end
            S_A1D0: begin
                HTRANS = TR_NONSEQ;
                HADDR  = a1_q;
                HSIZE  = lw_q ? 3'b010 : 3'b001;
                if (flush) begin
                    state_nxt = HREADY ? S_IDLE : S_FLSH;
                end else if (HRESP) begin
                    err_nxt   = HREADY;
                    state_nxt = HREADY ? S_IDLE : S_ERRW;
                end else if (HREADY) begin
                    rdy_nxt   = 1'b1;
                    cap_hi    = a0_q[1];
                    state_nxt = S_D1;
                end
            end
            S_D1: begin
                HADDR = a1_q;
                HSIZE = lw_q ? 3'b010 : 3'b001;
                if (flush) begin
                    state_nxt = HREADY ? S_IDLE : S_FLSH;
                end else if (HRESP) begin
                    err_nxt = HREADY;
                    if (HREADY)
                        state_nxt = S_IDLE;
                end else if (HREADY) begin
                    rdy_nxt   = 1'b1;
                    cap_hi    = a1_q[1];
                    state_nxt = S_IDLE;
                end
            end
            S_ERRW: begin
                if (HREADY) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FLSH: begin
                if (HREADY)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_opfetch.sv
// tb_mac_opfetch: directed bench for mac_opfetch. The bench plays the AHB
// slave cycle by cycle; expected operands go into a queue at request time and
// are popped whenever rdy is seen.
module tb_mac_opfetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_l, flush;
    logic [31:0] addr0, addr1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;
    logic [31:0] rslt;
    logic        rdy, bsy, err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] exp_q[$];

    mac_opfetch #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_l(req_l),
        .addr0(addr0), .addr1(addr1), .flush(flush),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .rslt(rslt), .rdy(rdy), .bsy(bsy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every rdy pulse must match the oldest expected operand.
    always @(negedge clk) begin
        if (rst && rdy) begin
            rdy_cnt++;
            if (exp_q.size() == 0)
                chk("unexpected_rdy", 32'd1, 32'd0);
            else
                chk("rslt", rslt, exp_q.pop_front());
        end
        if (rst && err)
            err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, e0;
        rst = 1'b0; req = 1'b0; req_l = 1'b1; flush = 1'b0;
        addr0 = '0; addr1 = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_outs", {28'd0, rdy, bsy, err, 1'b0}, 32'd0);
        chk("rst_rslt", rslt, 32'd0);
        rst = 1'b1;
        tick();

        // L fetch, zero wait
        req = 1'b1; req_l = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
        exp_q.push_back(32'h11223344); exp_q.push_back(32'h55667788);
        tick(); req = 1'b0;                                     // T+1
        chk("l_t1_htrans", {30'd0, HTRANS}, 32'd2);
        chk("l_t1_haddr", HADDR, 32'h100);
        chk("l_t1_hsize", {29'd0, HSIZE}, 32'd2);
        chk("l_t1_bsy", {31'd0, bsy}, 32'd1);
        tick();                                                  // T+2
        chk("l_t2_haddr", HADDR, 32'h200);
        chk("l_t2_htrans", {30'd0, HTRANS}, 32'd2);
        chk("l_t2_rdy", {31'd0, rdy}, 32'd0);
        HRDATA = 32'h11223344;
        tick();                                                  // T+3
        chk("l_t3_rdy", {31'd0, rdy}, 32'd1);
        chk("l_t3_htrans", {30'd0, HTRANS}, 32'd0);
        chk("l_t3_bsy", {31'd0, bsy}, 32'd1);
        HRDATA = 32'h55667788;
        tick();                                                  // T+4
        chk("l_t4_rdy", {31'd0, rdy}, 32'd1);
        chk("l_t4_bsy", {31'd0, bsy}, 32'd0);
        HRDATA = 32'hDEADBEEF;
        tick();
        chk("l_rdy_count", rdy_cnt, 32'd2);

        // W fetch, big-endian lane select
        req = 1'b1; req_l = 1'b0; addr0 = 32'h102; addr1 = 32'h200;
        exp_q.push_back(32'h00008001); exp_q.push_back(32'h00001234);
        tick(); req = 1'b0;
        chk("w_t1_hsize", {29'd0, HSIZE}, 32'd1);
        chk("w_t1_haddr", HADDR, 32'h102);
        tick();
        chk("w_t2_hsize", {29'd0, HSIZE}, 32'd1);
        HRDATA = 32'hAAAA8001;
        tick();
        HRDATA = 32'h1234ABCD;
        tick();
        tick();
        chk("w_rdy_count", rdy_cnt, 32'd4);

        // Two wait states on op0 data phase
        req = 1'b1; req_l = 1'b1; addr0 = 32'h300; addr1 = 32'h404;
        exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'h0BADC0DE);
        tick(); req = 1'b0;                                     // T+1
        tick(); HREADY = 1'b0; HRDATA = 32'h0;                   // T+2
        tick();                                                  // T+3
        chk("ws_haddr_hold", HADDR, 32'h404);
        chk("ws_htrans_hold", {30'd0, HTRANS}, 32'd2);
        tick(); HREADY = 1'b1; HRDATA = 32'hCAFEF00D;            // T+4
        chk("ws_t4_rdy", {31'd0, rdy}, 32'd0);
        tick(); HRDATA = 32'h0BADC0DE;                           // T+5
        chk("ws_t5_rdy", {31'd0, rdy}, 32'd1);
        tick();                                                  // T+6
        chk("ws_t6_rdy", {31'd0, rdy}, 32'd1);
        chk("ws_t6_bsy", {31'd0, bsy}, 32'd0);
        tick();

        // Error response on op0
        r0 = rdy_cnt; e0 = err_cnt;
        req = 1'b1; req_l = 1'b1; addr0 = 32'h500; addr1 = 32'h600;
        tick(); req = 1'b0;                                     // T+1
        tick(); HREADY = 1'b0; HRESP = 1'b1;                     // T+2 error cycle 1
        tick();                                                  // T+3
        chk("err_htrans_idle", {30'd0, HTRANS}, 32'd0);
        HREADY = 1'b1;                                           // error cycle 2
        tick(); HRESP = 1'b0;                                    // T+4
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_bsy", {31'd0, bsy}, 32'd0);
        tick(); tick();
        chk("err_once", err_cnt - e0, 32'd1);
        chk("err_no_rdy", rdy_cnt - r0, 32'd0);

        // Flush during A1D0
        r0 = rdy_cnt; e0 = err_cnt;
        req = 1'b1; req_l = 1'b1; addr0 = 32'h700; addr1 = 32'h800;
        tick(); req = 1'b0;                                     // T+1
        tick(); flush = 1'b1; HRDATA = 32'h99999999;             // T+2
        tick(); flush = 1'b0;                                    // T+3
        chk("fl_bsy", {31'd0, bsy}, 32'd0);
        chk("fl_htrans", {30'd0, HTRANS}, 32'd0);
        req = 1'b1; addr0 = 32'h900; addr1 = 32'hA00;
        exp_q.push_back(32'h01020304); exp_q.push_back(32'h05060708);
        tick(); req = 1'b0;
        chk("fl_newreq_htrans", {30'd0, HTRANS}, 32'd2);
        chk("fl_newreq_haddr", HADDR, 32'h900);
        tick(); HRDATA = 32'h01020304;
        tick(); HRDATA = 32'h05060708;
        tick(); tick();
        chk("fl_rdy_count", rdy_cnt - r0, 32'd2);
        chk("fl_no_err", err_cnt - e0, 32'd0);

        // Misaligned addr1
        r0 = rdy_cnt; e0 = err_cnt;
        req = 1'b1; req_l = 1'b1; addr0 = 32'hB00; addr1 = 32'h203;
`ifdef MAC_OPF_MISALIGN_EN
        tick(); req = 1'b0;
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_htrans", {30'd0, HTRANS}, 32'd0);
        chk("mis_bsy", {31'd0, bsy}, 32'd0);
        tick(); tick();
        chk("mis_no_rdy", rdy_cnt - r0, 32'd0);
`else
        exp_q.push_back(32'h13572468); exp_q.push_back(32'h24681357);
        tick(); req = 1'b0;
        tick();
        chk("mis_haddr_aligned", HADDR, 32'h200);
        HRDATA = 32'h13572468;
        tick(); HRDATA = 32'h24681357;
        tick(); tick();
        chk("mis_rdy_count", rdy_cnt - r0, 32'd2);
        chk("mis_no_err", err_cnt - e0, 32'd0);
`endif

        // Reset asserted mid-transfer
        r0 = rdy_cnt;
        req = 1'b1; req_l = 1'b1; addr0 = 32'hC00; addr1 = 32'hD00;
        tick(); req = 1'b0;
        tick(); HRDATA = 32'h77777777;
        rst = 1'b0; #1;
        chk("rstmid_bsy", {31'd0, bsy}, 32'd0);
        chk("rstmid_htrans", {30'd0, HTRANS}, 32'd0);
        tick(); rst = 1'b1;
        tick(); tick();
        chk("rstmid_no_rdy", rdy_cnt - r0, 32'd0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
